// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone/secondary-port BRAM arbiter.
// Holds the FSM state encoding, requester port indices and the byte-strobe width.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int PORT_M0   = 0;
  localparam int PORT_M1   = 1;
  localparam int NUM_PORTS = 2;
  localparam int STRB_W    = 4;
  localparam int DATA_W    = 32;

  // Byte-write enables seen by the BRAM: strobes only matter for writes.
  function automatic logic [STRB_W-1:0] write_mask(input logic [STRB_W-1:0] strb,
                                                    input logic              we);
    return strb & {STRB_W{we}};
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter producing a one-hot grant; ties alternate against last_grant.
// Build option ARB_M0_PRIORITY_EN: ties always go to m0 and last_grant is ignored.
module rr_arbiter2
  import wb_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 last_grant,
  output logic [NUM_PORTS-1:0] grant
);

`ifdef ARB_M0_PRIORITY_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant = '0;
    if (req[PORT_M0]) begin
      grant[PORT_M0] = 1'b1;
    end else if (req[PORT_M1]) begin
      grant[PORT_M1] = 1'b1;
    end
  end
`else
  always_comb begin
    grant = '0;
    if (req[PORT_M0] && req[PORT_M1]) begin
      // The port that did not win last time gets this tie.
      if (last_grant == 1'(PORT_M1)) begin
        grant[PORT_M0] = 1'b1;
      end else begin
        grant[PORT_M1] = 1'b1;
      end
    end else begin
      grant = req;
    end
  end
`endif

endmodule

// File: rtl/wb_bram_arbiter.sv
// Shares one BRAM port between a Wishbone classic slave (m0) and a UART DMA requester (m1).
// Build option ARB_M0_PRIORITY_EN selects fixed m0 priority instead of round-robin on ties.
module wb_bram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DELAYS = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic              m0_ack_o,
  output logic [31:0]       m0_dat_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_wstrb_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_done_o,
  output logic [31:0]       m1_rdata_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_a_o,
  output logic [31:0]       bram_di_o,
  input  logic [31:0]       bram_do_i,
  output logic              busy_o
);

  localparam int CNT_W = (DELAYS < 1) ? 1 : $clog2(DELAYS + 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [NUM_PORTS-1:0] gnt_reg;
  logic                 last_grant_reg;
  logic                 we_reg;
  logic [STRB_W-1:0]    strb_reg;
  logic [ADDR_W-1:0]    addr_reg;
  logic [DATA_W-1:0]    wdata_reg;
  logic [DATA_W-1:0]    rdata_reg;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] resp;
  logic [STRB_W-1:0]    we_mask;
  logic                 start;
  logic                 last_cycle;
  logic                 first_cycle;
  logic                 m0_abort;

  // Only the word-address bits of the Wishbone address reach the BRAM.
  logic unused_adr;
  assign unused_adr = ^{m0_adr_i[31:ADDR_W+2], m0_adr_i[1:0]};

  assign req[PORT_M0] = m0_cyc_i & m0_stb_i;
  assign req[PORT_M1] = m1_req_i;

  rr_arbiter2 u_arb (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign start       = (state_reg == IDLE) && (|req);
  assign first_cycle = (state_reg == ACCESS) && (cnt_reg == '0);
  assign last_cycle  = (cnt_reg == CNT_W'(DELAYS));
  // m1 holds its request until done, so only a Wishbone master can walk away.
  assign m0_abort    = (state_reg == ACCESS) && gnt_reg[PORT_M0] && !m0_cyc_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (m0_abort) begin
          state_next = IDLE;
        end else if (last_cycle) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      gnt_reg        <= '0;
      last_grant_reg <= 1'(PORT_M1);
      we_reg         <= 1'b0;
      strb_reg       <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else if (start) begin
      cnt_reg        <= '0;
      gnt_reg        <= grant;
      last_grant_reg <= grant[PORT_M1];
      if (grant[PORT_M0]) begin
        we_reg    <= m0_we_i;
        strb_reg  <= m0_sel_i;
        addr_reg  <= m0_adr_i[ADDR_W+1:2];
        wdata_reg <= m0_dat_i;
      end else begin
        we_reg    <= m1_we_i;
        strb_reg  <= m1_wstrb_i;
        addr_reg  <= m1_addr_i;
        wdata_reg <= m1_wdata_i;
      end
    end else if (state_reg == ACCESS) begin
      cnt_reg <= cnt_reg + 1'b1;
      // BRAM output has been stable since the cycle after enable; take it on the way out.
      if (last_cycle && !we_reg && !m0_abort) begin
        rdata_reg <= bram_do_i;
      end
    end
  end

  assign we_mask = write_mask(strb_reg, we_reg);

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      assign bram_we_o[gi] = first_cycle & we_mask[gi];
    end
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign resp[gi] = (state_reg == RESP) & gnt_reg[gi];
    end
  endgenerate

  assign bram_en_o  = (state_reg == ACCESS);
  assign bram_a_o   = addr_reg;
  assign bram_di_o  = wdata_reg;
  assign m0_ack_o   = resp[PORT_M0];
  assign m1_done_o  = resp[PORT_M1];
  assign m0_dat_o   = rdata_reg;
  assign m1_rdata_o = rdata_reg;
  assign busy_o     = (state_reg != IDLE);

endmodule
